// File: rtl/seq_det_ctrl.sv
// Purpose : run-time programmable serial pattern detector with its own run controller
//           (load pattern/len/threshold, arm on start, count matches, stop at threshold).
// Latency : match/done/match_cnt register on the edge that samples the completing bit.
// Backpressure: none; din is consumed only when din_vld=1, and gaps hold all state.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_we          config write strobe (honoured in IDLE/DONE only)
//   cfg_pat/len/thr pattern (bit [len-1] received first), length, match threshold (0 = unlimited)
//   start, stop     run control pulses (stop wins over everything)
//   din_vld, din    qualified serial input
//   match           1-cycle pulse per detected pattern
//   match_cnt       saturating match count for the current run
//   busy            high while the run is active (FILL or RUN)
//   done            1-cycle pulse when match_cnt reaches a nonzero threshold
//
// Build option: define SEQ_DET_OVERLAP_EN to keep history after a match so that
// overlapping occurrences are counted; otherwise each match restarts the fill.

module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thr,
    input  logic             start,
    input  logic             stop,
    input  logic             din_vld,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               done_q, done_d;

    // Effective length: 0 behaves as 1, anything above PAT_W clamps to PAT_W.
    logic [LEN_W-1:0]   len_eff;
    logic [PAT_W-1:0]   len_mask;

    always_comb begin
        len_eff = len_q;
        if (len_q == '0) begin
            len_eff = LEN_W'(1);
        end else if (len_q > LEN_W'(PAT_W)) begin
            len_eff = LEN_W'(PAT_W);
        end
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_eff));
        end
    end

    logic [PAT_W-1:0]   shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W:0]     cnt_inc;
    logic               pat_hit;
    logic               thr_hit;

    assign shifted  = {hist_q[PAT_W-2:0], din};
    assign fill_inc = fill_q + LEN_W'(1);
    assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    // Compare includes the bit being shifted in this cycle.
    assign pat_hit  = ((shifted ^ pat_q) & len_mask) == '0;
    // cnt_inc is one bit wider, so a saturated counter can never alias a threshold.
    assign thr_hit  = (thr_q != '0) && (cnt_inc == {1'b0, thr_q});

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        done_d  = 1'b0;

        if (cfg_we && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            pat_d = cfg_pat;
            len_d = cfg_len;
            thr_d = cfg_thr;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_FILL, ST_RUN: begin
                if (din_vld) begin
                    hist_d = shifted;
                    if (state_q == ST_FILL) begin
                        fill_d = fill_inc;
                    end
                    // The bit that completes FILL is already compared.
                    if (state_q == ST_RUN || fill_inc == len_eff) begin
                        state_d = ST_RUN;
                        if (pat_hit) begin
                            match_d = 1'b1;
                            cnt_d   = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
                            if (thr_hit) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
`ifdef SEQ_DET_OVERLAP_EN
                                state_d = ST_RUN;
`else
                                state_d = ST_FILL;
                                hist_d  = '0;
                                fill_d  = '0;
`endif
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort dominates start and any match on the same edge; count is held.
        if (stop) begin
            state_d = ST_IDLE;
            hist_d  = hist_q;
            fill_d  = fill_q;
            cnt_d   = cnt_q;
            match_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    assign match     = match_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q == ST_FILL) || (state_q == ST_RUN);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Purpose : self-checking bench for seq_det_ctrl (PAT_W=8, LEN_W=4, CNT_W=2).
// Latency : model predicts outputs one edge after the sampled inputs.
// Backpressure: not applicable; stimulus drives din_vld gaps directly.

module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_thr;
    logic             start;
    logic             stop;
    logic             din_vld;
    logic             din;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_thr   (cfg_thr),
        .start     (start),
        .stop      (stop),
        .din_vld   (din_vld),
        .din       (din),
        .match     (match),
        .match_cnt (match_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit         m_armed;
    int         m_cnt;
    bit         m_match;
    bit         m_done;
    logic [7:0] m_pat;
    int         m_len;
    int         m_thr;
    bit         m_bits[$];

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > PAT_W) return PAT_W;
        return l;
    endfunction

    // Last L received bits, oldest first, must equal pat[L-1] .. pat[0].
    function automatic bit tail_ok(input int l);
        int n;
        n = m_bits.size();
        for (int k = 0; k < l; k++) begin
            if (m_bits[n - l + k] != m_pat[l - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        int  l;
        bit  hit_thr;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_armed = 0; m_cnt = 0; m_match = 0; m_done = 0;
                m_pat = '0; m_len = 0; m_thr = 0;
                m_bits.delete();
            end else begin
                m_match = 0;
                m_done  = 0;
                if (cfg_we && !m_armed) begin
                    m_pat = cfg_pat;
                    m_len = int'(cfg_len);
                    m_thr = int'(cfg_thr);
                end
                if (stop) begin
                    m_armed = 0;
                end else if (!m_armed) begin
                    if (start) begin
                        m_armed = 1;
                        m_cnt   = 0;
                        m_bits.delete();
                    end
                end else if (din_vld) begin
                    m_bits.push_back(din);
                    if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                    l = eff_len(m_len);
                    if (m_bits.size() >= l && tail_ok(l)) begin
                        m_match = 1;
                        hit_thr = (m_thr != 0) && (m_cnt + 1 == m_thr);
                        if (m_cnt < CNT_MAX) m_cnt++;
                        if (hit_thr) begin
                            m_armed = 0;
                            m_done  = 1;
                        end else if (!OVL) begin
                            m_bits.delete();
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("match",     int'(match),     int'(m_match));
            check("match_cnt", int'(match_cnt), m_cnt);
            check("busy",      int'(busy),      int'(m_armed));
            check("done",      int'(done),      int'(m_done));
            if (match) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b);
        din     = b;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        din     = 1'($urandom);
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    task automatic do_cfg(input logic [7:0] p, input int l, input int t);
        cfg_pat = p;
        cfg_len = LEN_W'(l);
        cfg_thr = CNT_W'(t);
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic pstart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pstop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; cfg_we = 0; cfg_pat = '0; cfg_len = '0; cfg_thr = '0;
        start = 0; stop = 0; din_vld = 0; din = 0;
        tick(); tick();
        @(negedge clk);
        check("rst_match", int'(match), 0);
        check("rst_cnt",   int'(match_cnt), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic 1101 detection
        do_cfg(8'h0D, 4, 0);
        pstart();
        send_seq(16'b1101, 4);
        @(negedge clk);
        check("t1_match", int'(match), 1);
        check("t1_cnt",   int'(match_cnt), 1);
        check("t1_busy",  int'(busy), 1);

        // overlap behaviour on 1101101
        pstop();
        pstart();
        p0 = pulses;
        send_seq(16'b1101101, 7);
        tick();
        check("t2_pulses", pulses - p0, OVL ? 2 : 1);
        check("t2_cnt",    int'(match_cnt), OVL ? 2 : 1);

        // threshold ends run; later bits ignored
        pstop();
        do_cfg(8'h0D, 4, 2);
        pstart();
        p0 = pulses;
        send_seq(16'b11011101, 8);
        @(negedge clk);
        check("t3_match", int'(match), 1);
        check("t3_done",  int'(done), 1);
        check("t3_busy",  int'(busy), 0);
        check("t3_cnt",   int'(match_cnt), 2);
        send_seq(16'b1101, 4);
        tick();
        check("t3_pulses", pulses - p0, 2);
        check("t3_hold",   int'(match_cnt), 2);

        // din_vld gaps are transparent
        pstop();
        do_cfg(8'h0D, 4, 0);
        pstart();
        p0 = pulses;
        send(1); send(1);
        repeat (3) begin din = 1'($urandom); tick(); end
        send(0); send(1);
        tick();
        check("t4_pulses", pulses - p0, 1);
        check("t4_cnt",    int'(match_cnt), 1);

        // stop+start together in RUN, cfg_we ignored while busy
        send_seq(16'b0000, 4);
        cfg_pat = 8'h00; cfg_len = 4'd4; cfg_thr = '0;
        cfg_we = 1; stop = 1; start = 1;
        tick();
        cfg_we = 0; stop = 0; start = 0;
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_cnt",  int'(match_cnt), 1);
        pstart();
        p0 = pulses;
        send_seq(16'b00001101, 8);
        tick();
        check("t5_pulses", pulses - p0, 1);
        check("t5_cnt2",   int'(match_cnt), 1);

        // length above PAT_W clamps to PAT_W
        pstop();
        do_cfg(8'hB3, 15, 0);
        pstart();
        send_seq(16'hB3, 8);
        @(negedge clk);
        check("clamp_match", int'(match), 1);

        // length 0 acts as 1; counter saturates at 3
        pstop();
        do_cfg(8'h01, 0, 0);
        pstart();
        p0 = pulses;
        send_seq(16'b11111, 5);
        tick();
        check("t6_pulses", pulses - p0, 5);
        check("t6_cnt",    int'(match_cnt), 3);

        // reset while a match is pending
        send(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_match", int'(match), 0);
        check("t6_rst_cnt",   int'(match_cnt), 0);
        check("t6_rst_busy",  int'(busy), 0);
        check("t6_rst_done",  int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // config regs reset to 0: len 0 -> 1, pattern bit 0
        pstart();
        send(0);
        @(negedge clk);
        check("rst_cfg_match", int'(match), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
